// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared repeat-FSM state encoding and counter width helpers
package button_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      REPEAT = 2'd2
   } rpt_state_t;

   // Never returns zero so a counter sized from a tiny count still has one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one input channel: synchroniser, debouncer, edge pulses, auto-repeat
module button_channel
   import button_pkg::*;
#(
   parameter int DB_COUNT      = 1000,
   parameter int REPEAT_DELAY  = 50000,
   parameter int REPEAT_PERIOD = 10000,
   parameter bit repeat_en     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int DW = cnt_width(DB_COUNT);
   localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [DW-1:0] DB_LAST     = DW'(DB_COUNT - 1);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   logic          sync1;
   logic          sync2;
   logic [DW-1:0] db_cnt;
   logic          accept;
   logic          accept_rise;
   logic          accept_fall;
   logic          repeat_fire;
   rpt_state_t    state;
   rpt_state_t    state_nx;
   logic [RW-1:0] rpt_cnt;
   logic [RW-1:0] rpt_cnt_nx;

   assign accept      = (sync2 != level) && (db_cnt == DB_LAST);
   assign accept_rise = accept & sync2;
   assign accept_fall = accept & ~sync2;

   // Any sample matching the current level restarts the stability count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         db_cnt     <= '0;
         level      <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == level) begin
            db_cnt <= '0;
         end else if (accept) begin
            level  <= sync2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DW'(1);
         end
         rise_pulse <= accept_rise | repeat_fire;
         fall_pulse <= accept_fall;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rpt_cnt <= '0;
      end else begin
         state   <= state_nx;
         rpt_cnt <= rpt_cnt_nx;
      end
   end

   // An accepted release always wins over a repeat falling due on the same cycle.
   always_comb begin
      state_nx    = state;
      rpt_cnt_nx  = rpt_cnt;
      repeat_fire = 1'b0;
      case (state)
         IDLE: begin
            rpt_cnt_nx = '0;
            if (repeat_en && accept_rise) begin
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (accept_fall) begin
               state_nx   = IDLE;
               rpt_cnt_nx = '0;
            end else if (rpt_cnt == DELAY_LAST) begin
               state_nx    = REPEAT;
               rpt_cnt_nx  = '0;
               repeat_fire = 1'b1;
            end else begin
               rpt_cnt_nx = rpt_cnt + RW'(1);
            end
         end
         REPEAT: begin
            if (accept_fall) begin
               state_nx   = IDLE;
               rpt_cnt_nx = '0;
            end else if (rpt_cnt == PERIOD_LAST) begin
               rpt_cnt_nx  = '0;
               repeat_fire = 1'b1;
            end else begin
               rpt_cnt_nx = rpt_cnt + RW'(1);
            end
         end
         default: begin
            state_nx   = IDLE;
            rpt_cnt_nx = '0;
         end
      endcase
   end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - N_CH independent button conditioning channels
module button_conditioner
   import button_pkg::*;
#(
   parameter int              N_CH          = 3,
   parameter int              DB_COUNT      = 1000,
   parameter int              REPEAT_DELAY  = 50000,
   parameter int              REPEAT_PERIOD = 10000,
   parameter logic [N_CH-1:0] REPEAT_MASK   = 3'b001
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] raw_in,
   output logic [N_CH-1:0] level_out,
   output logic [N_CH-1:0] rise_pulse,
   output logic [N_CH-1:0] fall_pulse
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      button_channel #(
         .DB_COUNT      (DB_COUNT),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD),
         .repeat_en     (REPEAT_MASK[i])
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .raw        (raw_in[i]),
         .level      (level_out[i]),
         .rise_pulse (rise_pulse[i]),
         .fall_pulse (fall_pulse[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized and directed checks against a sliding-window reference model
module tb_button_conditioner;

   localparam int N = 3;
   localparam int DB = 4;
   localparam int DLY = 8;
   localparam int PER = 3;
   localparam logic [2:0] MASK = 3'b001;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] raw_in = 3'b000;
   logic [2:0] level_out;
   logic [2:0] rise_pulse;
   logic [2:0] fall_pulse;

   int checks = 0;
   int errors = 0;

   // Reference model: raw samples since reset; level flips when the last DB synchronised samples all differ.
   logic [2:0] mq[$];
   int         k = 0;
   int         last_edge = 0;
   logic [2:0] m_lvl = 3'b000;
   logic [2:0] e_rise = 3'b000;
   logic [2:0] e_fall = 3'b000;
   int         rise_edge[3];

   always #5 clk = ~clk;

   button_conditioner #(
      .N_CH          (N),
      .DB_COUNT      (DB),
      .REPEAT_DELAY  (DLY),
      .REPEAT_PERIOD (PER),
      .REPEAT_MASK   (MASK)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw_in     (raw_in),
      .level_out  (level_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
   );

   task automatic model_clear();
      mq.delete();
      k = 0;
      m_lvl = 3'b000;
      e_rise = 3'b000;
      e_fall = 3'b000;
   endtask

   task automatic tick();
      logic [2:0] smp;
      logic sv;
      logic diff;
      int d;
      @(posedge clk);
      e_rise = 3'b000;
      e_fall = 3'b000;
      for (int c = 0; c < N; c++) begin
         diff = 1'b1;
         for (int j = 0; j < DB; j++) begin
            sv = 1'b0;
            if (k - j >= 2) begin
               smp = mq[k - j - 2];
               sv = smp[c];
            end
            if (sv == m_lvl[c]) diff = 1'b0;
         end
         if (diff) begin
            m_lvl[c] = ~m_lvl[c];
            if (m_lvl[c]) begin
               e_rise[c] = 1'b1;
               rise_edge[c] = k;
            end else begin
               e_fall[c] = 1'b1;
            end
         end else if (m_lvl[c] && MASK[c]) begin
            d = k - rise_edge[c];
            if (d >= DLY && (d - DLY) % PER == 0) e_rise[c] = 1'b1;
         end
      end
      mq.push_back(raw_in);
      last_edge = k;
      k++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      raw_in = 3'b000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      raw_in = 3'b111;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if ({level_out, rise_pulse, fall_pulse} !== {m_lvl, e_rise, e_fall}) begin
            errors++;
            $display("FAIL reset_run edge %0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
                     last_edge, level_out, rise_pulse, fall_pulse, m_lvl, e_rise, e_fall);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({level_out, rise_pulse, fall_pulse} !== 9'd0) begin
         errors++;
         $display("FAIL async_reset got l=%b r=%b f=%b exp all 0", level_out, rise_pulse, fall_pulse);
      end
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if ({level_out, rise_pulse, fall_pulse} !== {m_lvl, e_rise, e_fall}) begin
            errors++;
            $display("FAIL post_reset edge %0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
                     last_edge, level_out, rise_pulse, fall_pulse, m_lvl, e_rise, e_fall);
         end
         if (i == 4) begin
            checks++;
            if (level_out !== 3'b000) begin
               errors++;
               $display("FAIL reset_latency_early got %b exp 000", level_out);
            end
         end
         if (i == 5) begin
            checks++;
            if (level_out !== 3'b111 || rise_pulse !== 3'b111) begin
               errors++;
               $display("FAIL reset_latency got l=%b r=%b exp l=111 r=111", level_out, rise_pulse);
            end
         end
      end
   endtask

   task automatic test_single_ch1();
      int nrise;
      nrise = 0;
      raw_in = 3'b000;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if ({level_out, rise_pulse, fall_pulse} !== {m_lvl, e_rise, e_fall}) begin
            errors++;
            $display("FAIL ch1_settle edge %0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
                     last_edge, level_out, rise_pulse, fall_pulse, m_lvl, e_rise, e_fall);
         end
      end
      raw_in[1] = 1'b1;
      for (int i = 1; i <= 24; i++) begin
         tick();
         checks++;
         if ({level_out, rise_pulse, fall_pulse} !== {m_lvl, e_rise, e_fall}) begin
            errors++;
            $display("FAIL ch1_model edge %0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
                     last_edge, level_out, rise_pulse, fall_pulse, m_lvl, e_rise, e_fall);
         end
         if (i == 5) begin
            checks++;
            if (level_out[1] !== 1'b0) begin
               errors++;
               $display("FAIL ch1_early got %b exp 0", level_out[1]);
            end
         end
         if (i == 6) begin
            checks++;
            if (level_out[1] !== 1'b1 || rise_pulse[1] !== 1'b1) begin
               errors++;
               $display("FAIL ch1_latency got l=%b r=%b exp l=1 r=1", level_out[1], rise_pulse[1]);
            end
         end
         if (i > 6 && rise_pulse[1] === 1'b1) nrise++;
      end
      checks++;
      if (nrise !== 0) begin
         errors++;
         $display("FAIL ch1_no_repeat got %0d rise pulses exp 0", nrise);
      end
   endtask

   task automatic test_short_and_bounce();
      logic [5:0] bp;
      int act;
      int nrise;
      bp = 6'b111101;
      act = 0;
      nrise = 0;
      raw_in = 3'b000;
      for (int i = 0; i < 26; i++) begin
         if (i == 10) raw_in[0] = 1'b1;
         if (i == 13) raw_in[0] = 1'b0;
         tick();
         checks++;
         if ({level_out, rise_pulse, fall_pulse} !== {m_lvl, e_rise, e_fall}) begin
            errors++;
            $display("FAIL short_model edge %0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
                     last_edge, level_out, rise_pulse, fall_pulse, m_lvl, e_rise, e_fall);
         end
         if (i >= 10 && (level_out[0] | rise_pulse[0] | fall_pulse[0]) === 1'b1) act++;
      end
      checks++;
      if (act !== 0) begin
         errors++;
         $display("FAIL short_pulse got %0d active cycles exp 0", act);
      end
      for (int i = 0; i < 13; i++) begin
         raw_in[0] = (i < 6) ? bp[i] : 1'b1;
         tick();
         checks++;
         if ({level_out, rise_pulse, fall_pulse} !== {m_lvl, e_rise, e_fall}) begin
            errors++;
            $display("FAIL bounce_model edge %0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
                     last_edge, level_out, rise_pulse, fall_pulse, m_lvl, e_rise, e_fall);
         end
         if (rise_pulse[0] === 1'b1) nrise++;
      end
      checks++;
      if (nrise !== 1) begin
         errors++;
         $display("FAIL bounce_rise got %0d rise pulses exp 1", nrise);
      end
      raw_in = 3'b000;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if ({level_out, rise_pulse, fall_pulse} !== {m_lvl, e_rise, e_fall}) begin
            errors++;
            $display("FAIL bounce_settle edge %0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
                     last_edge, level_out, rise_pulse, fall_pulse, m_lvl, e_rise, e_fall);
         end
      end
   endtask

   task automatic test_repeat();
      int t0;
      int fe;
      int rq[$];
      t0 = -1;
      fe = -1;
      raw_in[0] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (t0 >= 0 && i == t0 + 20) raw_in[0] = 1'b0;
         tick();
         checks++;
         if ({level_out, rise_pulse, fall_pulse} !== {m_lvl, e_rise, e_fall}) begin
            errors++;
            $display("FAIL repeat_model edge %0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
                     last_edge, level_out, rise_pulse, fall_pulse, m_lvl, e_rise, e_fall);
         end
         if (rise_pulse[0] === 1'b1) begin
            if (t0 < 0) t0 = i;
            else rq.push_back(i - t0);
         end
         if (fall_pulse[0] === 1'b1 && t0 >= 0) fe = i - t0;
      end
      checks++;
      if (t0 !== 5) begin
         errors++;
         $display("FAIL repeat_first got %0d exp 5", t0);
      end
      checks++;
      if (rq.size() !== 6) begin
         errors++;
         $display("FAIL repeat_count got %0d exp 6", rq.size());
      end
      for (int n = 0; n < rq.size() && n < 6; n++) begin
         checks++;
         if (rq[n] !== DLY + PER * n) begin
            errors++;
            $display("FAIL repeat_time %0d got %0d exp %0d", n, rq[n], DLY + PER * n);
         end
      end
      checks++;
      if (fe !== 25) begin
         errors++;
         $display("FAIL repeat_release got %0d exp 25", fe);
      end
   endtask

   task automatic test_simultaneous();
      raw_in = 3'b111;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if ({level_out, rise_pulse, fall_pulse} !== {m_lvl, e_rise, e_fall}) begin
            errors++;
            $display("FAIL simul_rise_model edge %0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
                     last_edge, level_out, rise_pulse, fall_pulse, m_lvl, e_rise, e_fall);
         end
         if (i == 5) begin
            checks++;
            if (rise_pulse !== 3'b111 || level_out !== 3'b111) begin
               errors++;
               $display("FAIL simul_rise got r=%b l=%b exp r=111 l=111", rise_pulse, level_out);
            end
         end
      end
      raw_in = 3'b000;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if ({level_out, rise_pulse, fall_pulse} !== {m_lvl, e_rise, e_fall}) begin
            errors++;
            $display("FAIL simul_fall_model edge %0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
                     last_edge, level_out, rise_pulse, fall_pulse, m_lvl, e_rise, e_fall);
         end
         if (i == 5) begin
            checks++;
            if (fall_pulse !== 3'b111 || rise_pulse !== 3'b000) begin
               errors++;
               $display("FAIL simul_fall got f=%b r=%b exp f=111 r=000", fall_pulse, rise_pulse);
            end
         end
      end
   endtask

   task automatic test_release_on_repeat();
      int t0;
      int stray;
      int nrise;
      t0 = -1;
      stray = 0;
      nrise = 0;
      raw_in[0] = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (t0 >= 0 && i == t0 + 9) raw_in[0] = 1'b0;
         tick();
         checks++;
         if ({level_out, rise_pulse, fall_pulse} !== {m_lvl, e_rise, e_fall}) begin
            errors++;
            $display("FAIL rel_model edge %0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
                     last_edge, level_out, rise_pulse, fall_pulse, m_lvl, e_rise, e_fall);
         end
         if (t0 < 0 && rise_pulse[0] === 1'b1) t0 = i;
         if (t0 >= 0 && i == t0 + 14) begin
            checks++;
            if (fall_pulse[0] !== 1'b1 || rise_pulse[0] !== 1'b0) begin
               errors++;
               $display("FAIL rel_on_repeat got f=%b r=%b exp f=1 r=0", fall_pulse[0], rise_pulse[0]);
            end
         end
         if (t0 >= 0 && i > t0 + 14 && rise_pulse[0] === 1'b1) stray++;
      end
      checks++;
      if (stray !== 0) begin
         errors++;
         $display("FAIL rel_stray got %0d rise pulses exp 0", stray);
      end
      raw_in[0] = 1'b1;
      for (int i = 0; i < 14; i++) begin
         tick();
         checks++;
         if ({level_out, rise_pulse, fall_pulse} !== {m_lvl, e_rise, e_fall}) begin
            errors++;
            $display("FAIL rel_repress_model edge %0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
                     last_edge, level_out, rise_pulse, fall_pulse, m_lvl, e_rise, e_fall);
         end
         if (rise_pulse[0] === 1'b1) nrise++;
      end
      checks++;
      if (nrise !== 2) begin
         errors++;
         $display("FAIL rel_repress got %0d rise pulses exp 2", nrise);
      end
   endtask

   task automatic test_random();
      int hold;
      for (int s = 0; s < 80; s++) begin
         raw_in = 3'($urandom_range(0, 7));
         hold = $urandom_range(1, 9);
         for (int h = 0; h < hold; h++) begin
            tick();
            checks++;
            if ({level_out, rise_pulse, fall_pulse} !== {m_lvl, e_rise, e_fall}) begin
               errors++;
               $display("FAIL random_model edge %0d got l=%b r=%b f=%b exp l=%b r=%b f=%b",
                        last_edge, level_out, rise_pulse, fall_pulse, m_lvl, e_rise, e_fall);
            end
         end
         if ($urandom_range(0, 15) == 0) begin
            #2 rst_n = 1'b0;
            #1;
            checks++;
            if ({level_out, rise_pulse, fall_pulse} !== 9'd0) begin
               errors++;
               $display("FAIL random_reset got l=%b r=%b f=%b exp all 0", level_out, rise_pulse, fall_pulse);
            end
            model_clear();
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_ch1();
      test_short_and_bounce();
      test_repeat();
      test_simultaneous();
      test_release_on_repeat();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
